// File: rtl/ctrl_pkg.sv
// Shared widths, bundle bit positions and NOP constants for the control pipeline.
package ctrl_pkg;
  localparam int CTRL_REG_W = 5;
  localparam int CTRL_WB_W  = 2;
  localparam int CTRL_EX_W  = 4;
  localparam int CTRL_MEM_W = 2;

  localparam int EX_ALUSRC   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_REGDST   = 0;
  localparam int MEM_WRITE   = 1;
  localparam int MEM_READ    = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [CTRL_WB_W-1:0]  WB_NOP  = '0;
  localparam logic [CTRL_EX_W-1:0]  EX_NOP  = '0;
  localparam logic [CTRL_MEM_W-1:0] MEM_NOP = '0;
endpackage

// File: rtl/ctrl_pipe_if.sv
// Decoder-side bundles in, per-stage unpacked control out.
interface ctrl_pipe_if
  import ctrl_pkg::*;
#(
  parameter int REG_W = CTRL_REG_W,
  parameter int WB_W  = CTRL_WB_W,
  parameter int EX_W  = CTRL_EX_W,
  parameter int MEM_W = CTRL_MEM_W
);
  logic             hold_i;
  logic             flush_i;
  logic [WB_W-1:0]  WB_i;
  logic [EX_W-1:0]  EX_i;
  logic [MEM_W-1:0] MEM_i;
  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic [REG_W-1:0] id_rd_i;

  logic             stall_o;
  logic             ex_alusrc_o;
  logic [1:0]       ex_aluop_o;
  logic [REG_W-1:0] ex_rt_o;
  logic             mem_memwrite_o;
  logic             mem_memread_o;
  logic             mem_regwrite_o;
  logic [REG_W-1:0] mem_wr_reg_o;
  logic             wb_regwrite_o;
  logic             wb_memtoreg_o;
  logic [REG_W-1:0] wb_wr_reg_o;

  modport master (
    output hold_i, flush_i, WB_i, EX_i, MEM_i, id_rs_i, id_rt_i, id_rd_i,
    input  stall_o, ex_alusrc_o, ex_aluop_o, ex_rt_o, mem_memwrite_o,
           mem_memread_o, mem_regwrite_o, mem_wr_reg_o, wb_regwrite_o,
           wb_memtoreg_o, wb_wr_reg_o
  );

  modport slave (
    input  hold_i, flush_i, WB_i, EX_i, MEM_i, id_rs_i, id_rt_i, id_rd_i,
    output stall_o, ex_alusrc_o, ex_aluop_o, ex_rt_o, mem_memwrite_o,
           mem_memread_o, mem_regwrite_o, mem_wr_reg_o, wb_regwrite_o,
           wb_memtoreg_o, wb_wr_reg_o
  );
endinterface

// File: rtl/ctrl_pipe_hazard_detect.sv
// Load-use hazard check between the load in EX and the instruction in ID.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  output logic             stall
);
  logic hazard;

  // $0 is never a real dependence
  assign hazard = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign stall  = hazard && !flush;
endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with destination tracking and load-use stall.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W = CTRL_REG_W,
  parameter int WB_W  = CTRL_WB_W,
  parameter int EX_W  = CTRL_EX_W,
  parameter int MEM_W = CTRL_MEM_W
) (
  input logic       clk_i,
  input logic       rst_i,
  ctrl_pipe_if.slave bus
);
  logic [WB_W-1:0]  idex_wb, exmem_wb, memwb_wb;
  logic [MEM_W-1:0] idex_mem, exmem_mem;
  logic [EX_W-1:0]  idex_ex;
  logic [REG_W-1:0] idex_rt, idex_rd, exmem_wr, memwb_wr;
  logic [REG_W-1:0] ex_wr_reg;
  logic             stall, bubble;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_memread (idex_mem[MEM_READ]),
    .ex_rt      (idex_rt),
    .id_rs      (bus.id_rs_i),
    .id_rt      (bus.id_rt_i),
    .flush      (bus.flush_i),
    .stall      (stall)
  );

  assign bubble    = bus.flush_i || stall;
  assign ex_wr_reg = idex_ex[EX_REGDST] ? idex_rd : idex_rt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_wb   <= WB_NOP;
      idex_mem  <= MEM_NOP;
      idex_ex   <= EX_NOP;
      idex_rt   <= '0;
      idex_rd   <= '0;
      exmem_wb  <= WB_NOP;
      exmem_mem <= MEM_NOP;
      exmem_wr  <= '0;
      memwb_wb  <= WB_NOP;
      memwb_wr  <= '0;
    end else if (!bus.hold_i) begin
      // A bubble only zeroes ID/EX; older stages keep draining
      if (bubble) begin
        idex_wb  <= WB_NOP;
        idex_mem <= MEM_NOP;
        idex_ex  <= EX_NOP;
        idex_rt  <= '0;
        idex_rd  <= '0;
      end else begin
        idex_wb  <= bus.WB_i;
        idex_mem <= bus.MEM_i;
        idex_ex  <= bus.EX_i;
        idex_rt  <= bus.id_rt_i;
        idex_rd  <= bus.id_rd_i;
      end
      exmem_wb  <= idex_wb;
      exmem_mem <= idex_mem;
      exmem_wr  <= ex_wr_reg;
      memwb_wb  <= exmem_wb;
      memwb_wr  <= exmem_wr;
    end
  end

  assign bus.stall_o        = stall;
  assign bus.ex_alusrc_o    = idex_ex[EX_ALUSRC];
  assign bus.ex_aluop_o     = idex_ex[EX_ALUOP_HI:EX_ALUOP_LO];
  assign bus.ex_rt_o        = idex_rt;
  assign bus.mem_memwrite_o = exmem_mem[MEM_WRITE];
  assign bus.mem_memread_o  = exmem_mem[MEM_READ];
  assign bus.mem_regwrite_o = exmem_wb[WB_REGWRITE];
  assign bus.mem_wr_reg_o   = exmem_wr;
  assign bus.wb_regwrite_o  = memwb_wb[WB_REGWRITE];
  assign bus.wb_memtoreg_o  = memwb_wb[WB_MEMTOREG];
  assign bus.wb_wr_reg_o    = memwb_wr;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: reset, R-type flow, load-use, $0, flush, hold, reset mid-stall.
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ctrl_pipe_if bus ();
  ctrl_pipe u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [3:0] ex, input logic [1:0] mem,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.WB_i = wb; bus.EX_i = ex; bus.MEM_i = mem;
    bus.id_rs_i = rs; bus.id_rt_i = rt; bus.id_rd_i = rd;
  endtask

  // advance one edge, then settle
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; bus.hold_i = 1'b0; bus.flush_i = 1'b0;
    drive(2'b10, 4'b0101, 2'b00, 5'd1, 5'd3, 5'd7);
    step(); step();
    chk("rst_ex_aluop", 32'(bus.ex_aluop_o), 0);
    chk("rst_ex_rt", 32'(bus.ex_rt_o), 0);
    chk("rst_mem_regwrite", 32'(bus.mem_regwrite_o), 0);
    chk("rst_mem_wr_reg", 32'(bus.mem_wr_reg_o), 0);
    chk("rst_wb_regwrite", 32'(bus.wb_regwrite_o), 0);
    chk("rst_wb_wr_reg", 32'(bus.wb_wr_reg_o), 0);
    chk("rst_stall", 32'(bus.stall_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ex_aluop", 32'(bus.ex_aluop_o), 0);

    // R-type: rd=7 selected by RegDst
    step();
    drive(2'b00, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd0);
    chk("r_ex_aluop", 32'(bus.ex_aluop_o), 2);
    chk("r_ex_alusrc", 32'(bus.ex_alusrc_o), 0);
    chk("r_ex_rt", 32'(bus.ex_rt_o), 3);
    step();
    chk("r_mem_wr_reg", 32'(bus.mem_wr_reg_o), 7);
    chk("r_mem_regwrite", 32'(bus.mem_regwrite_o), 1);
    chk("r_mem_memread", 32'(bus.mem_memread_o), 0);
    step();
    chk("r_wb_wr_reg", 32'(bus.wb_wr_reg_o), 7);
    chk("r_wb_regwrite", 32'(bus.wb_regwrite_o), 1);
    chk("r_wb_memtoreg", 32'(bus.wb_memtoreg_o), 0);

    // Load-use via rs
    drive(2'b11, 4'b1000, 2'b01, 5'd0, 5'd5, 5'd0);
    step();
    drive(2'b10, 4'b0101, 2'b00, 5'd5, 5'd6, 5'd8);
    #1;
    chk("lu_stall", 32'(bus.stall_o), 1);
    chk("lu_ex_alusrc", 32'(bus.ex_alusrc_o), 1);
    step();
    chk("lu_bubble_aluop", 32'(bus.ex_aluop_o), 0);
    chk("lu_bubble_rt", 32'(bus.ex_rt_o), 0);
    chk("lu_mem_memread", 32'(bus.mem_memread_o), 1);
    chk("lu_mem_wr_reg", 32'(bus.mem_wr_reg_o), 5);
    chk("lu_release", 32'(bus.stall_o), 0);
    step();
    drive(2'b00, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd0);
    chk("lu_dep_aluop", 32'(bus.ex_aluop_o), 2);
    chk("lu_dep_rt", 32'(bus.ex_rt_o), 6);
    chk("lu_mem_regwrite_bubble", 32'(bus.mem_regwrite_o), 0);
    chk("lu_wb_memtoreg", 32'(bus.wb_memtoreg_o), 1);
    chk("lu_wb_wr_reg", 32'(bus.wb_wr_reg_o), 5);

    // Load to $0 never stalls
    drive(2'b11, 4'b1000, 2'b01, 5'd0, 5'd0, 5'd0);
    step();
    drive(2'b10, 4'b0101, 2'b00, 5'd0, 5'd0, 5'd4);
    #1;
    chk("z_stall", 32'(bus.stall_o), 0);

    // Flush overrides stall
    drive(2'b11, 4'b1000, 2'b01, 5'd0, 5'd9, 5'd0);
    step();
    drive(2'b10, 4'b0101, 2'b00, 5'd9, 5'd2, 5'd3);
    bus.flush_i = 1'b1;
    #1;
    chk("fl_stall", 32'(bus.stall_o), 0);
    step();
    bus.flush_i = 1'b0;
    drive(2'b00, 4'b1000, 2'b10, 5'd0, 5'd11, 5'd0);
    chk("fl_bubble_aluop", 32'(bus.ex_aluop_o), 0);
    chk("fl_mem_memread", 32'(bus.mem_memread_o), 1);
    chk("fl_mem_wr_reg", 32'(bus.mem_wr_reg_o), 9);

    // Hold: sw sits in ID/EX for three frozen edges
    step();
    chk("h_ex_alusrc", 32'(bus.ex_alusrc_o), 1);
    chk("h_wb_wr_reg", 32'(bus.wb_wr_reg_o), 9);
    bus.hold_i = 1'b1;
    drive(2'b10, 4'b0101, 2'b00, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("h_frz_ex_alusrc", 32'(bus.ex_alusrc_o), 1);
      chk("h_frz_ex_rt", 32'(bus.ex_rt_o), 11);
      chk("h_frz_mem_memwrite", 32'(bus.mem_memwrite_o), 0);
      chk("h_frz_wb_wr_reg", 32'(bus.wb_wr_reg_o), 9);
    end
    bus.hold_i = 1'b0;
    drive(2'b00, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd0);
    step();
    chk("h_mem_memwrite", 32'(bus.mem_memwrite_o), 1);
    chk("h_mem_regwrite", 32'(bus.mem_regwrite_o), 0);
    chk("h_ex_alusrc_after", 32'(bus.ex_alusrc_o), 0);

    // Reset mid-stall, dependence through rt
    drive(2'b11, 4'b1000, 2'b01, 5'd0, 5'd5, 5'd0);
    step();
    drive(2'b10, 4'b0101, 2'b00, 5'd1, 5'd5, 5'd8);
    #1;
    chk("rs_stall_rt", 32'(bus.stall_o), 1);
    rst = 1'b1;
    step();
    chk("rs_stall_cleared", 32'(bus.stall_o), 0);
    chk("rs_mem_memread", 32'(bus.mem_memread_o), 0);
    chk("rs_ex_rt", 32'(bus.ex_rt_o), 0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
